// File: rtl/osd_pkg.sv
// Shared colour codes, palette and lock-state type for the OSD overlay mixer.
package osd_pkg;

  localparam logic [1:0] BG_BLACK  = 2'd0;
  localparam logic [1:0] BG_BLUE   = 2'd1;
  localparam logic [1:0] BG_YELLOW = 2'd2;
  localparam logic [1:0] BG_WHITE  = 2'd3;

  // Palette entries are 8-bit {R,G,B}; the mixer MSB-aligns them to its channel width.
  localparam logic [23:0] PAL_BLACK  = 24'h000000;
  localparam logic [23:0] PAL_BLUE   = 24'h0000C0;
  localparam logic [23:0] PAL_YELLOW = 24'hFFFF00;
  localparam logic [23:0] PAL_WHITE  = 24'hFFFFFF;

  localparam int OSD_LATENCY_DEFAULT = 7;
  localparam logic [10:0] POS_MAX = 11'd2047;

  typedef enum logic {
    LS_UNLOCKED = 1'b0,
    LS_LOCKED   = 1'b1
  } lock_state_t;

  function automatic logic [23:0] paletteRgb(input logic [1:0] code);
    case (code)
      BG_BLACK:  return PAL_BLACK;
      BG_BLUE:   return PAL_BLUE;
      BG_YELLOW: return PAL_YELLOW;
      default:   return PAL_WHITE;
    endcase
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register for a bundled video word; every stage resets to i_resetValue.
module video_delay_line #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 27
) (
  input  logic             i_vclk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_resetValue,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_vclk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_resetValue;
    end else begin
      r_stage[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/osd_overlay_mixer.sv
// Raster counters, lock tracking and OSD mixing for the video output path.
// Define OSD_BLEND_EN to half-blend the blue background code instead of replacing video.
module osd_overlay_mixer
  import osd_pkg::*;
#(
  parameter int OSD_LATENCY = OSD_LATENCY_DEFAULT,
  parameter int COLOR_W     = 8
) (
  input  logic               vclk,
  input  logic               rst_i,
  input  logic [COLOR_W-1:0] R_i,
  input  logic [COLOR_W-1:0] G_i,
  input  logic [COLOR_W-1:0] B_i,
  input  logic               HSYNC_i,
  input  logic               VSYNC_i,
  input  logic               DE_i,
  output logic [10:0]        xpos,
  output logic [10:0]        ypos,
  input  logic               osd_enable,
  input  logic [1:0]         osd_color,
  output logic [COLOR_W-1:0] R_o,
  output logic [COLOR_W-1:0] G_o,
  output logic [COLOR_W-1:0] B_o,
  output logic               HSYNC_o,
  output logic               VSYNC_o,
  output logic               DE_o,
  output logic               locked
);

  localparam int VW = 3*COLOR_W + 3;
  localparam logic [VW-1:0] VID_RESET = {{(3*COLOR_W){1'b0}}, 3'b110};

  function automatic logic [COLOR_W-1:0] alignChan(input logic [7:0] v);
    return COLOR_W'({v, {COLOR_W{1'b0}}} >> 8);
  endfunction

  logic        r_deD, r_vsD;
  logic [10:0] r_xpos, r_ypos;
  logic        w_deFall, w_vsLead;
  lock_state_t r_lockState, w_lockNext;
  logic        w_locked;

  assign w_deFall = r_deD & ~DE_i;
  assign w_vsLead = r_vsD & ~VSYNC_i;

  // A line's first pixel (DE just rose) gets xpos 0, so restart on the previous DE.
  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      r_deD  <= 1'b0;
      r_vsD  <= 1'b1;
      r_xpos <= '0;
      r_ypos <= '0;
    end else begin
      r_deD <= DE_i;
      r_vsD <= VSYNC_i;
      if (DE_i && r_deD)
        r_xpos <= (r_xpos == POS_MAX) ? POS_MAX : r_xpos + 11'd1;
      else
        r_xpos <= '0;
      if (w_vsLead)
        r_ypos <= '0;
      else if (w_deFall && (r_ypos != POS_MAX))
        r_ypos <= r_ypos + 11'd1;
    end
  end

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) r_lockState <= LS_UNLOCKED;
    else       r_lockState <= w_lockNext;
  end

  // Lock drops when a line ends at ypos 2047 with no vsync to rewind the count.
  always_comb begin
    w_lockNext = r_lockState;
    w_locked   = 1'b0;
    case (r_lockState)
      LS_UNLOCKED: begin
        if (w_vsLead) w_lockNext = LS_LOCKED;
      end
      LS_LOCKED: begin
        w_locked = 1'b1;
        if (!w_vsLead && w_deFall && (r_ypos == POS_MAX)) w_lockNext = LS_UNLOCKED;
      end
      default: w_lockNext = LS_UNLOCKED;
    endcase
  end

  logic [VW-1:0]      w_vidIn, w_vidDly;
  logic [COLOR_W-1:0] w_dlyR, w_dlyG, w_dlyB;
  logic               w_dlyHs, w_dlyVs, w_dlyDe;

  assign w_vidIn = {R_i, G_i, B_i, HSYNC_i, VSYNC_i, DE_i};

  video_delay_line #(
    .DEPTH(OSD_LATENCY),
    .WIDTH(VW)
  ) u_delay (
    .i_vclk      (vclk),
    .i_rst       (rst_i),
    .i_resetValue(VID_RESET),
    .i_data      (w_vidIn),
    .o_data      (w_vidDly)
  );

  assign {w_dlyR, w_dlyG, w_dlyB, w_dlyHs, w_dlyVs, w_dlyDe} = w_vidDly;

  logic [23:0]        w_pal24;
  logic [COLOR_W-1:0] w_palR, w_palG, w_palB;
  logic               w_overlay;
  logic [COLOR_W-1:0] w_mixR, w_mixG, w_mixB;

  assign w_pal24   = paletteRgb(osd_color);
  assign w_palR    = alignChan(w_pal24[23:16]);
  assign w_palG    = alignChan(w_pal24[15:8]);
  assign w_palB    = alignChan(w_pal24[7:0]);
  assign w_overlay = w_dlyDe & osd_enable & w_locked;

  always_comb begin
    w_mixR = w_dlyR;
    w_mixG = w_dlyG;
    w_mixB = w_dlyB;
    if (w_overlay) begin
`ifdef OSD_BLEND_EN
      if (osd_color == BG_BLUE) begin
        w_mixR = (w_dlyR >> 1) + (w_palR >> 1);
        w_mixG = (w_dlyG >> 1) + (w_palG >> 1);
        w_mixB = (w_dlyB >> 1) + (w_palB >> 1);
      end else begin
        w_mixR = w_palR;
        w_mixG = w_palG;
        w_mixB = w_palB;
      end
`else
      w_mixR = w_palR;
      w_mixG = w_palG;
      w_mixB = w_palB;
`endif
    end
  end

  logic [COLOR_W-1:0] r_rOut, r_gOut, r_bOut;
  logic               r_hsOut, r_vsOut, r_deOut;

  always_ff @(posedge vclk or posedge rst_i) begin
    if (rst_i) begin
      r_rOut  <= '0;
      r_gOut  <= '0;
      r_bOut  <= '0;
      r_hsOut <= 1'b1;
      r_vsOut <= 1'b1;
      r_deOut <= 1'b0;
    end else begin
      r_rOut  <= w_mixR;
      r_gOut  <= w_mixG;
      r_bOut  <= w_mixB;
      r_hsOut <= w_dlyHs;
      r_vsOut <= w_dlyVs;
      r_deOut <= w_dlyDe;
    end
  end

  assign xpos    = r_xpos;
  assign ypos    = r_ypos;
  assign locked  = w_locked;
  assign R_o     = r_rOut;
  assign G_o     = r_gOut;
  assign B_o     = r_bOut;
  assign HSYNC_o = r_hsOut;
  assign VSYNC_o = r_vsOut;
  assign DE_o    = r_deOut;

endmodule

// File: tb/tb_osd_overlay_mixer.sv
// Randomized bench for osd_overlay_mixer against a frame-level reference model.
module tb_osd_overlay_mixer;

  localparam int L = 7;
  localparam logic [26:0] RST_VID = {24'h000000, 3'b110};

  logic        vclk = 1'b0;
  logic        rst_i;
  logic [7:0]  R_i, G_i, B_i;
  logic        HSYNC_i, VSYNC_i, DE_i, osd_enable;
  logic [1:0]  osd_color;
  logic [10:0] xpos, ypos;
  logic [7:0]  R_o, G_o, B_o;
  logic        HSYNC_o, VSYNC_o, DE_o, locked;
  logic [26:0] vidOut;

  assign vidOut = {R_o, G_o, B_o, HSYNC_o, VSYNC_o, DE_o};

  always #5 vclk = ~vclk;

  osd_overlay_mixer #(.OSD_LATENCY(L), .COLOR_W(8)) dut (
    .vclk(vclk), .rst_i(rst_i),
    .R_i(R_i), .G_i(G_i), .B_i(B_i),
    .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .DE_i(DE_i),
    .xpos(xpos), .ypos(ypos),
    .osd_enable(osd_enable), .osd_color(osd_color),
    .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .DE_o(DE_o),
    .locked(locked)
  );

  typedef struct {
    logic [23:0] rgb;
    logic [2:0]  syn;
    logic        oe;
    logic [1:0]  oc;
  } pix_t;

  pix_t        pipeQ[$];
  int          nVectors, nMiscompares;
  int          run, lines;
  bit          seenVs, prevDe, prevVs, lockPrev;
  logic [10:0] expX, expY;
  logic        expLock;
  logic [26:0] expVid;

  function automatic logic [23:0] palRgb(input logic [1:0] oc);
    case (oc)
      2'd0:    return 24'h000000;
      2'd1:    return 24'h0000C0;
      2'd2:    return 24'hFFFF00;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [23:0] mixModel(input pix_t p, input bit lockedNow);
    logic [23:0] pal;
    pal = palRgb(p.oc);
    if (!(p.syn[0] && p.oe && lockedNow)) return p.rgb;
`ifdef OSD_BLEND_EN
    if (p.oc == 2'd1)
      return {8'((p.rgb[23:16] >> 1) + (pal[23:16] >> 1)),
              8'((p.rgb[15:8]  >> 1) + (pal[15:8]  >> 1)),
              8'((p.rgb[7:0]   >> 1) + (pal[7:0]   >> 1))};
`endif
    return pal;
  endfunction

  // Frame layout: line 0 carries vsync (if enabled), line 1 blank, then vAct active lines.
  function automatic logic [2:0] rasterAt(input int l, input int p, input int hAct,
                                          input int vAct, input bit vsOn);
    logic de, hs, vs;
    de = (l >= 2) && (l < vAct + 2) && (p < hAct);
    hs = (p != hAct + 1);
    vs = !(vsOn && (l == 0));
    return {hs, vs, de};
  endfunction

  task automatic modelReset();
    pix_t idle;
    idle.rgb = 24'h0; idle.syn = 3'b110; idle.oe = 1'b0; idle.oc = 2'd0;
    pipeQ.delete();
    for (int i = 0; i < L; i++) pipeQ.push_back(idle);
    run = 0; lines = 0; seenVs = 0; prevDe = 0; prevVs = 1; lockPrev = 0;
  endtask

  // Drives one pixel plus the generator's answer for the pixel L clocks older.
  task automatic step(input logic [23:0] rgb, input logic [2:0] syn,
                      input logic oe, input logic [1:0] oc);
    pix_t cur, dly;
    logic hs, vs, de;
    {hs, vs, de} = syn;
    run = de ? run + 1 : 0;
    if (prevVs && !vs) begin
      lines = 0;
      seenVs = 1;
    end else if (prevDe && !de) begin
      lines++;
    end
    prevDe = de;
    prevVs = vs;
    expX = de ? 11'((run - 1 > 2047) ? 2047 : run - 1) : 11'd0;
    expY = 11'((lines > 2047) ? 2047 : lines);
    expLock = seenVs && (lines <= 2047);
    cur.rgb = rgb; cur.syn = syn; cur.oe = oe; cur.oc = oc;
    pipeQ.push_back(cur);
    dly = pipeQ.pop_front();
    {R_i, G_i, B_i} = rgb;
    HSYNC_i = hs; VSYNC_i = vs; DE_i = de;
    osd_enable = dly.oe;
    osd_color  = dly.oc;
    expVid = {mixModel(dly, lockPrev), dly.syn};
    lockPrev = expLock;
    @(posedge vclk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    R_i = 0; G_i = 0; B_i = 0; HSYNC_i = 1; VSYNC_i = 1; DE_i = 0;
    osd_enable = 0; osd_color = 0;
    repeat (3) @(posedge vclk);
    #1;
    nVectors++; if ({xpos, ypos} !== 22'd0) begin nMiscompares++; $display("FAIL reset_pos got %0d,%0d exp 0,0", xpos, ypos); end
    nVectors++; if (locked !== 1'b0) begin nMiscompares++; $display("FAIL reset_locked got %b exp 0", locked); end
    nVectors++; if (vidOut !== RST_VID) begin nMiscompares++; $display("FAIL reset_vid got %h exp %h", vidOut, RST_VID); end
    rst_i = 1'b0;
    modelReset();
  endtask

  task automatic test_unlocked();
    for (int l = 0; l < 6; l++)
      for (int p = 0; p < 18; p++) begin
        step(24'($urandom), rasterAt(l, p, 16, 4, 1'b0), 1'b1, 2'd3);
        nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL unlocked_pos got %0d,%0d exp %0d,%0d", xpos, ypos, expX, expY); end
        nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL unlocked_lock got %b exp %b", locked, expLock); end
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL unlocked_vid got %h exp %h", vidOut, expVid); end
      end
  endtask

  task automatic test_frames();
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 6; l++)
        for (int p = 0; p < 18; p++) begin
          step(24'($urandom), rasterAt(l, p, 16, 4, 1'b1), 1'b0, 2'd0);
          nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL frames_pos f=%0d l=%0d p=%0d got %0d,%0d exp %0d,%0d", f, l, p, xpos, ypos, expX, expY); end
          nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL frames_lock got %b exp %b", locked, expLock); end
          nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL frames_vid got %h exp %h", vidOut, expVid); end
        end
  endtask

  task automatic test_overlay_region();
    for (int l = 0; l < 6 + L; l++)
      for (int p = 0; p < 18; p++) begin
        step(24'($urandom), rasterAt(l, p, 16, 4, 1'b1),
             (l == 3) && (p >= 4) && (p <= 7), 2'd2);
        nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL region_pos got %0d,%0d exp %0d,%0d", xpos, ypos, expX, expY); end
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL region_vid l=%0d p=%0d got %h exp %h", l, p, vidOut, expVid); end
      end
  endtask

  task automatic test_random_overlay();
    for (int f = 0; f < 3; f++) begin
      int hAct = int'($urandom_range(8, 24));
      for (int l = 0; l < 7; l++)
        for (int p = 0; p < hAct + 2; p++) begin
          step(24'($urandom), rasterAt(l, p, hAct, 5, 1'b1), 1'($urandom), 2'($urandom));
          nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL random_pos got %0d,%0d exp %0d,%0d", xpos, ypos, expX, expY); end
          nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL random_lock got %b exp %b", locked, expLock); end
          nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL random_vid got %h exp %h", vidOut, expVid); end
        end
    end
  endtask

  task automatic test_xsat();
    for (int l = 0; l < 4; l++)
      for (int p = 0; p < 2054; p++) begin
        step(24'($urandom), rasterAt(l, p, 2052, 1, 1'b1), 1'($urandom), 2'($urandom));
        nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL xsat_pos p=%0d got %0d,%0d exp %0d,%0d", p, xpos, ypos, expX, expY); end
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL xsat_vid got %h exp %h", vidOut, expVid); end
      end
  endtask

  task automatic test_lock_loss();
    for (int l = 0; l < 2102; l++)
      for (int p = 0; p < 4; p++) begin
        step(24'($urandom), rasterAt(l, p, 2, 2100, 1'b1), 1'($urandom), 2'($urandom));
        nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL loss_pos l=%0d got %0d,%0d exp %0d,%0d", l, xpos, ypos, expX, expY); end
        nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL loss_lock l=%0d got %b exp %b", l, locked, expLock); end
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL loss_vid l=%0d got %h exp %h", l, vidOut, expVid); end
      end
    for (int l = 0; l < 5; l++)
      for (int p = 0; p < 10; p++) begin
        step(24'($urandom), rasterAt(l, p, 8, 3, 1'b1), 1'($urandom), 2'($urandom));
        nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL relock_pos got %0d,%0d exp %0d,%0d", xpos, ypos, expX, expY); end
        nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL relock_lock got %b exp %b", locked, expLock); end
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL relock_vid got %h exp %h", vidOut, expVid); end
      end
  endtask

  task automatic test_reset_midline();
    for (int f = 0; f < 3; f++)
      for (int l = 0; l < 6; l++)
        for (int p = 0; p < 18; p++) begin
          step(24'($urandom), rasterAt(l, p, 16, 4, 1'b1), 1'($urandom), 2'($urandom));
          nVectors++; if ({xpos, ypos} !== {expX, expY}) begin nMiscompares++; $display("FAIL midrst_pos got %0d,%0d exp %0d,%0d", xpos, ypos, expX, expY); end
          nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL midrst_lock got %b exp %b", locked, expLock); end
          nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL midrst_vid got %h exp %h", vidOut, expVid); end
          if (f == 0 && l == 3 && p == 6) begin
            rst_i = 1'b1;
            #1;
            nVectors++; if ({xpos, ypos, locked} !== 23'd0) begin nMiscompares++; $display("FAIL midrst_async_pos got %0d,%0d,%b exp 0,0,0", xpos, ypos, locked); end
            nVectors++; if (vidOut !== RST_VID) begin nMiscompares++; $display("FAIL midrst_async_vid got %h exp %h", vidOut, RST_VID); end
            @(posedge vclk);
            #1;
            rst_i = 1'b0;
            modelReset();
          end
        end
  endtask

  task automatic test_blend();
    for (int l = 0; l < 4 + L; l++)
      for (int p = 0; p < 18; p++) begin
        step(24'h804020, rasterAt(l, p, 16, 2, 1'b1), (l == 2) && (p < 8), (p < 4) ? 2'd1 : 2'd3);
        nVectors++; if (vidOut !== expVid) begin nMiscompares++; $display("FAIL blend_vid l=%0d p=%0d got %h exp %h", l, p, vidOut, expVid); end
        nVectors++; if (locked !== expLock) begin nMiscompares++; $display("FAIL blend_lock got %b exp %b", locked, expLock); end
      end
  endtask

  initial begin
    nVectors = 0;
    nMiscompares = 0;
    test_reset();
    test_unlocked();
    test_frames();
    test_overlay_region();
    test_random_overlay();
    test_xsat();
    test_lock_loss();
    test_reset_midline();
    test_blend();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
